// File: rtl/sdi_video_timing_if.sv
// sdi_video_timing_if: control and video bus of the SD-SDI raster sequencer.
// Ports: enable/tx_ready/vid_ce toward the sequencer; vid_active, vid_data[59:0], vid_field,
// vid_hblank, vid_vblank, sof, frame_count[15:0], running back from it. The sequencer is the slave.
interface sdi_video_timing_if;
    logic        enable;
    logic        tx_ready;
    logic        vid_ce;
    logic        vid_active;
    logic [59:0] vid_data;
    logic        vid_field;
    logic        vid_hblank;
    logic        vid_vblank;
    logic        sof;
    logic [15:0] frame_count;
    logic        running;
    modport master(
        output enable, tx_ready, vid_ce,
        input  vid_active, vid_data, vid_field, vid_hblank, vid_vblank, sof, frame_count, running
    );
    modport slave(
        input  enable, tx_ready, vid_ce,
        output vid_active, vid_data, vid_field, vid_hblank, vid_vblank, sof, frame_count, running
    );
endinterface

// File: rtl/sdi_video_timing.sv
// sdi_video_timing: 525i raster sequencer feeding 4:2:2 words to the SD-SDI transmitter.
// Ports: sdi_tx_clk, sdi_tx_rst (async, active high), vif (slave modport of sdi_video_timing_if).
// Define SDI_VTG_COLORBARS_EN to fill active video with eight 75% colour bars instead of black.
module sdi_video_timing #(
    parameter int H_ACTIVE     = 720,
    parameter int H_TOTAL      = 858,
    parameter int V_TOTAL      = 525,
    parameter int F1_ACT_FIRST = 20,
    parameter int F1_ACT_LAST  = 263,
    parameter int F2_ACT_FIRST = 283,
    parameter int F2_ACT_LAST  = 525,
    parameter int FIELD1_FIRST = 4,
    parameter int FIELD2_FIRST = 266
) (
    input logic                sdi_tx_clk,
    input logic                sdi_tx_rst,
    sdi_video_timing_if.slave  vif
);
    localparam int H_WORDS = 2 * H_TOTAL;
    localparam int A_WORDS = 2 * H_ACTIVE;
    localparam int HW      = $clog2(H_WORDS);
    localparam int LW      = $clog2(V_TOTAL + 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_WORDS - 1);
    localparam logic [LW-1:0] L_LAST = LW'(V_TOTAL);

    typedef enum logic [1:0] {IDLE, WAIT, RUN, STOP} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [LW-1:0] line_q, line_d;
    logic          active_q, active_d;
    logic [9:0]    data_q, data_d;
    logic          field_q, field_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic          sof_q, sof_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          running_q, running_d;

    logic          live, drop, adv, eol, eof;
    logic [31:0]   hc, ln;
    logic          hb, vb, act;
    logic [9:0]    word;

`ifdef SDI_VTG_COLORBARS_EN
    localparam int BAR_W = A_WORDS / 8;
    localparam int BW    = $clog2(BAR_W + 1);
    // Packed index 0 is the leftmost bar (white), so the lists run black..white.
    localparam logic [7:0][9:0] BAR_Y  = {10'h040, 10'h08C, 10'h104, 10'h150,
                                          10'h1C0, 10'h20C, 10'h288, 10'h2D0};
    localparam logic [7:0][9:0] BAR_CB = {10'h200, 10'h350, 10'h190, 10'h2E0,
                                          10'h120, 10'h270, 10'h0B0, 10'h200};
    localparam logic [7:0][9:0] BAR_CR = {10'h200, 10'h1C8, 10'h350, 10'h318,
                                          10'h0E8, 10'h0B0, 10'h238, 10'h200};
    logic [BW-1:0] bar_word_q, bar_word_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
`endif

    always_comb begin
        live = state_q == RUN || state_q == STOP;
        // Losing the transceiver overrides every other condition, including a pending enable.
        drop = state_q != IDLE && !vif.tx_ready;
        adv  = live && !drop && vif.vid_ce;
        eol  = h_cnt_q == H_LAST;
        eof  = eol && line_q == L_LAST;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = vif.enable ? WAIT : IDLE;
            WAIT:    state_d = !vif.enable ? IDLE : vif.tx_ready ? RUN : WAIT;
            RUN:     state_d = vif.enable ? RUN : STOP;
            default: state_d = vif.enable ? RUN : (vif.vid_ce && eof) ? IDLE : STOP;
        endcase
        if (drop)
            state_d = IDLE;
        h_cnt_d = adv ? (eol ? '0 : h_cnt_q + HW'(1)) : h_cnt_q;
        line_d  = (adv && eol) ? (line_q == L_LAST ? LW'(1) : line_q + LW'(1)) : line_q;
        if (state_d == IDLE) begin
            h_cnt_d = '0;
            line_d  = LW'(1);
        end
        hc   = 32'(h_cnt_q);
        ln   = 32'(line_q);
        hb   = hc >= A_WORDS;
        vb   = !((ln >= F1_ACT_FIRST && ln <= F1_ACT_LAST) || (ln >= F2_ACT_FIRST && ln <= F2_ACT_LAST));
        act  = !hb && !vb;
        // Word order Cb, Y, Cr, Y: odd words are luma.
        word = h_cnt_q[0] ? 10'h040 : 10'h200;
`ifdef SDI_VTG_COLORBARS_EN
        bar_word_d = bar_word_q;
        bar_idx_d  = bar_idx_q;
        if (adv) begin
            bar_word_d = (eol || bar_word_q == BW'(BAR_W - 1)) ? '0 : bar_word_q + BW'(1);
            bar_idx_d  = eol ? '0 : (bar_word_q == BW'(BAR_W - 1)) ? bar_idx_q + 3'd1 : bar_idx_q;
        end
        if (state_d == IDLE) begin
            bar_word_d = '0;
            bar_idx_d  = '0;
        end
        if (act)
            word = h_cnt_q[0] ? BAR_Y[bar_idx_q] : h_cnt_q[1] ? BAR_CR[bar_idx_q] : BAR_CB[bar_idx_q];
`endif
        active_d = active_q;
        data_d   = data_q;
        field_d  = field_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        sof_d    = 1'b0;
        if (!live || drop) begin
            active_d = 1'b0;
            data_d   = '0;
            field_d  = 1'b0;
            hblank_d = 1'b1;
            vblank_d = 1'b1;
        end else if (vif.vid_ce) begin
            active_d = act;
            data_d   = word;
            field_d  = ln >= FIELD2_FIRST || ln < FIELD1_FIRST;
            hblank_d = hb;
            vblank_d = vb;
            sof_d    = h_cnt_q == '0 && line_q == LW'(1);
        end
        frame_count_d = frame_count_q + 16'(sof_d);
        running_d     = live;
    end

    always_ff @(posedge sdi_tx_clk or posedge sdi_tx_rst) begin
        if (sdi_tx_rst) begin
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            line_q        <= LW'(1);
            active_q      <= 1'b0;
            data_q        <= '0;
            field_q       <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            sof_q         <= 1'b0;
            frame_count_q <= '0;
            running_q     <= 1'b0;
`ifdef SDI_VTG_COLORBARS_EN
            bar_word_q    <= '0;
            bar_idx_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            line_q        <= line_d;
            active_q      <= active_d;
            data_q        <= data_d;
            field_q       <= field_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            sof_q         <= sof_d;
            frame_count_q <= frame_count_d;
            running_q     <= running_d;
`ifdef SDI_VTG_COLORBARS_EN
            bar_word_q    <= bar_word_d;
            bar_idx_q     <= bar_idx_d;
`endif
        end
    end

    assign vif.vid_active  = active_q;
    assign vif.vid_data    = {50'b0, data_q};
    assign vif.vid_field   = field_q;
    assign vif.vid_hblank  = hblank_q;
    assign vif.vid_vblank  = vblank_q;
    assign vif.sof         = sof_q;
    assign vif.frame_count = frame_count_q;
    assign vif.running     = running_q;
endmodule

// File: tb/tb_sdi_video_timing.sv
// tb_sdi_video_timing: randomized-strobe bench for sdi_video_timing on a reduced raster.
module tb_sdi_video_timing;
    localparam int HA = 16, HT = 20, VT = 25;
    localparam int F1A = 3, F1L = 11, F2A = 15, F2L = 25, FD1 = 2, FD2 = 13;
    localparam int LWD = 2 * HT;
    localparam int FW  = LWD * VT;

    logic clk = 1'b0;
    logic rst;
    sdi_video_timing_if vif();

    sdi_video_timing #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_TOTAL(VT),
        .F1_ACT_FIRST(F1A), .F1_ACT_LAST(F1L), .F2_ACT_FIRST(F2A), .F2_ACT_LAST(F2L),
        .FIELD1_FIRST(FD1), .FIELD2_FIRST(FD2)
    ) dut (
        .sdi_tx_clk(clk),
        .sdi_tx_rst(rst),
        .vif(vif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int BY[8]  = '{'h2D0, 'h288, 'h20C, 'h1C0, 'h150, 'h104, 'h08C, 'h040};
    int BCB[8] = '{'h200, 'h0B0, 'h270, 'h120, 'h2E0, 'h190, 'h350, 'h200};
    int BCR[8] = '{'h200, 'h238, 'h0B0, 'h0E8, 'h318, 'h350, 'h1C8, 'h200};

    // Model: mst 0 idle, 1 waiting for GT, 2 running, 3 finishing frame; p = word index in frame.
    int          mst, p;
    logic        e_act, e_fld, e_hb, e_vb, e_sof, e_run;
    logic [9:0]  e_dat;
    logic [15:0] e_fc;
    int          cyc_n, last_sof, sof_gap;

    task automatic idle_out();
        e_act = 1'b0; e_dat = '0; e_fld = 1'b0; e_hb = 1'b1; e_vb = 1'b1; e_sof = 1'b0;
    endtask

    task automatic decode(input int q);
        int h, ln, y, cb, cr;
        h  = q % LWD;
        ln = q / LWD + 1;
        e_hb  = h >= 2 * HA;
        e_vb  = !((ln >= F1A && ln <= F1L) || (ln >= F2A && ln <= F2L));
        e_act = !e_hb && !e_vb;
        e_fld = ln >= FD2 || ln < FD1;
        y = 'h040; cb = 'h200; cr = 'h200;
`ifdef SDI_VTG_COLORBARS_EN
        if (e_act) begin
            y  = BY[h / (2 * HA / 8)];
            cb = BCB[h / (2 * HA / 8)];
            cr = BCR[h / (2 * HA / 8)];
        end
`endif
        e_dat = 10'(h % 2 == 1 ? y : h % 4 == 0 ? cb : cr);
    endtask

    task automatic model(input logic en, input logic tr, input logic ce);
        e_run = mst >= 2;
        if (mst != 0 && !tr) begin
            mst = 0; p = 0; idle_out();
        end else if (mst < 2) begin
            idle_out();
            mst = (mst == 0) ? (en ? 1 : 0) : (!en ? 0 : 2);
        end else begin
            e_sof = 1'b0;
            if (ce) begin
                decode(p);
                e_sof = p == 0;
                if (p == 0) e_fc = e_fc + 16'd1;
            end
            if (mst == 2) mst = en ? 2 : 3;
            else mst = en ? 2 : (ce && p == FW - 1) ? 0 : 3;
            if (ce) p = (p + 1) % FW;
        end
    endtask

    task automatic check(input string tag);
        logic [81:0] o, x;
        o = {vif.vid_active, vif.vid_data, vif.vid_field, vif.vid_hblank, vif.vid_vblank,
             vif.sof, vif.frame_count, vif.running};
        x = {e_act, 50'b0, e_dat, e_fld, e_hb, e_vb, e_sof, e_fc, e_run};
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s cyc=%0d obs=%h exp=%h", tag, cyc_n, o, x);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, o, x);
        end
    endtask

    task automatic cyc(input logic en, input logic tr, input logic ce, input string tag);
        @(negedge clk);
        vif.enable = en; vif.tx_ready = tr; vif.vid_ce = ce;
        model(en, tr, ce);
        @(posedge clk);
        #1;
        cyc_n++;
        if (vif.sof) begin
            sof_gap = cyc_n - last_sof;
            last_sof = cyc_n;
        end
        check(tag);
    endtask

    task automatic model_reset();
        mst = 0; p = 0; e_fc = '0; e_run = 1'b0; idle_out();
    endtask

    function automatic int cur_line();
        return p / LWD + 1;
    endfunction

    initial begin
        logic en, tr;
        cyc_n = 0; last_sof = 0; sof_gap = 0;
        rst = 1'b1; vif.enable = 1'b0; vif.tx_ready = 1'b0; vif.vid_ce = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset");
        @(negedge clk) rst = 1'b0;

        repeat (100) cyc(1'b1, 1'b0, 1'($urandom % 2), "no_ready");
        for (int i = 0; i < 2 * FW + 50; i++) cyc(1'b1, 1'b1, 1'b1, "ce_full");
        chk_int("frame_len_full", sof_gap, FW);

        for (int i = 0; i < 10 * FW + 10; i++) cyc(1'b1, 1'b1, 1'(i % 5 == 0), "ce_1in5");
        chk_int("frame_len_1in5", sof_gap, 5 * FW);

        for (int i = 0; i < 4 * FW && cur_line() != 5; i++) cyc(1'b1, 1'b1, 1'($urandom % 2), "to_l5");
        for (int i = 0; i < 4 * FW && vif.running; i++) cyc(1'b0, 1'b1, 1'($urandom % 2), "stop");
        chk_int("stop_done", int'(vif.running), 0);
        repeat (20) cyc(1'b0, 1'b1, 1'($urandom % 2), "idle");

        for (int i = 0; i < 4 * FW && cur_line() != 5; i++) cyc(1'b1, 1'b1, 1'($urandom % 2), "restart");
        for (int i = 0; i < 4 * FW && cur_line() != 18; i++) cyc(1'b0, 1'b1, 1'($urandom % 2), "stop_l18");
        for (int i = 0; i < 2 * FW; i++) cyc(1'b1, 1'b1, 1'b1, "reenable");
        chk_int("fc_continuous", int'(vif.frame_count), int'(e_fc));

        for (int i = 0; i < 4 * FW && cur_line() != 8; i++) cyc(1'b1, 1'b1, 1'($urandom % 2), "to_l8");
        cyc(1'b1, 1'b0, 1'b1, "tx_drop");
        repeat (5) cyc(1'b1, 1'b0, 1'($urandom % 2), "tx_low");
        for (int i = 0; i < FW + FW / 2; i++) cyc(1'b1, 1'b1, 1'($urandom % 3 != 0), "tx_restart");

        en = 1'b1; tr = 1'b1;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom % 400 == 0) en = !en;
            if ($urandom % 900 == 0) tr = !tr;
            cyc(en, tr, 1'($urandom % 3 != 0), "random");
        end

        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 1'b1, "pre_rst");
        @(negedge clk) rst = 1'b1;
        #1;
        model_reset();
        check("async_rst");
        @(posedge clk);
        #1 check("held_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdi_video_timing.md
# sdi_video_timing

Raster sequencer for the SD-SDI transmit path: generates 525i (NTSC) horizontal/vertical/field timing and 4:2:2 word data for the SDI transmitter's video input bus, advancing one word per transmitter clock-enable. Sits between the transceiver status (ready) and the transmitter; its enable/ready state machine starts raster output only after the GT is up and always stops on a frame boundary.

## Interface
- H_ACTIVE, 720, active pixels per line (2*H_ACTIVE words)
- H_TOTAL, 858, total pixels per line (2*H_TOTAL words)
- V_TOTAL, 525, lines per frame, numbered 1..V_TOTAL
- F1_ACT_FIRST / F1_ACT_LAST, 20 / 263, field-1 active lines (inclusive)
- F2_ACT_FIRST / F2_ACT_LAST, 283 / 525, field-2 active lines (inclusive)
- FIELD1_FIRST / FIELD2_FIRST, 4 / 266, first line of each field
- sdi_tx_clk  in  1  SDI transmit clock; only clock
- sdi_tx_rst  in  1  asynchronous, active-high reset
- enable  in  1  level; request raster output
- tx_ready  in  1  level; GT reset done/ready
- vid_ce  in  1  word strobe from transmitter; any duty cycle, up to every cycle
- vid_active  out  1  active video
- vid_data  out  60  word in [9:0]; [59:10] always 0
- vid_field  out  1  0 = field 1, 1 = field 2
- vid_hblank / vid_vblank  out  1  horizontal / vertical blanking
- sof  out  1  one-cycle start-of-frame pulse
- frame_count  out  16  frames started, wraps 0xFFFF->0
- running  out  1  state is RUN or STOP

## Operation
- Counters: h_cnt 0..2*H_TOTAL-1 (words), line 1..V_TOTAL. On vid_ce in RUN/STOP: h_cnt++; at 2*H_TOTAL-1 wrap to 0 and line++; line V_TOTAL wraps to 1.
- Decode of current (h_cnt, line): hblank = h_cnt >= 2*H_ACTIVE; vblank = line outside both active ranges; active = !hblank && !vblank; field = 1 when line >= FIELD2_FIRST or line < FIELD1_FIRST.
- Word order by h_cnt[1:0]: 0 Cb, 1 Y, 2 Cr, 3 Y. Blanking words: Y 0x040, C 0x200.
- Active words: black (Y 0x040, C 0x200) unless pattern macro compiled in.
- States: IDLE -> WAIT when enable=1. WAIT -> RUN when tx_ready=1; WAIT -> IDLE when enable=0. RUN -> STOP when enable=0. STOP -> RUN when enable=1 (no disturbance to counters); STOP -> IDLE on the vid_ce that consumes h_cnt=2*H_TOTAL-1, line=V_TOTAL. tx_ready=0 in WAIT/RUN/STOP -> IDLE immediately.
- Entering IDLE resets h_cnt=0, line=1. RUN always begins at (0,1).
- In IDLE/WAIT outputs held at: active 0, hblank 1, vblank 1, field 0, data 0.
- sof/frame_count: on the edge registering word (0,1); frame_count increments on that edge.

## Timing
- Reset: state IDLE, vid_active 0, vid_data 0, vid_field 0, vid_hblank 1, vid_vblank 1, sof 0, frame_count 0, running 0, h_cnt 0, line 1.
- Latency: all video outputs registered; on a clock edge with vid_ce=1 in RUN/STOP, outputs take the decode of the current (h_cnt, line), then counters advance. Outputs hold between strobes.
- First word after RUN entry: first vid_ce in RUN registers (0,1) with sof=1.
- sof high exactly one sdi_tx_clk cycle regardless of vid_ce spacing.
- running asserts the edge after WAIT->RUN; deasserts the edge after entering IDLE.
- Simultaneous enable=0 and tx_ready=0: tx_ready wins (IDLE).
- Reset mid-frame: immediate return to reset values, no final sof.

## Configuration
- SDI_VTG_COLORBARS_EN defined: active words carry eight 75% vertical bars, each 2*H_ACTIVE/8 words (180 at defaults), order white, yellow, cyan, green, magenta, red, blue, black; 10-bit (Y,Cb,Cr): (0x2D0,0x200,0x200), (0x288,0x0B0,0x238), (0x20C,0x270,0x0B0), (0x1C0,0x120,0x0E8), (0x150,0x2E0,0x318), (0x104,0x190,0x350), (0x08C,0x350,0x1C8), (0x040,0x200,0x200). Bar index from a separate bar counter reset at h_cnt=0; no divider.
- Undefined: active words are black; bar logic absent.

## Test plan
- Reset, enable=1, tx_ready=0 for 100 cycles -> running=0, hblank=vblank=1, no sof; then tx_ready=1, vid_ce every cycle -> running=1, sof on first strobe, frame_count=1.
- Full frame, vid_ce every cycle -> 1716*525=900900 strobes between sofs; hblank rises at h_cnt 1440; active lines 20-263 and 283-525 only; field=1 from line 266 through line 3.
- vid_ce 1-in-5 -> outputs stable between strobes, sof one cycle wide, frame length 4504500 cycles.
- enable=0 at line 100 -> continues to end of line 525, then running=0; re-enable at line 300 instead -> no gap, frame_count continuous.
- tx_ready=0 mid-frame -> IDLE next edge, outputs at IDLE values; restart begins at (0,1) with sof.
- With SDI_VTG_COLORBARS_EN, line 20 -> words 0..3 = 0x200,0x2D0,0x200,0x2D0; word 180 = 0x0B0 (yellow Cb); without macro -> all active words 0x200/0x040.
